// File: rtl/debug_uart_ctrl.sv
// debug_uart_ctrl: decodes host command bytes into pipeline run/halt/step control and
// serialises a header plus NUM_WORDS debug words, MSB first, to the UART transmitter.
module debug_uart_ctrl #(
  parameter int         NUM_WORDS = 44,
  parameter int         IDX_W     = 6,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] CMD_STEP  = 8'h73,
  parameter logic [7:0] CMD_RUN   = 8'h63,
  parameter logic [7:0] CMD_HALT  = 8'h68,
  parameter logic [7:0] CMD_DUMP  = 8'h64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_done_tick,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_done_tick,
  output logic [IDX_W-1:0] dbg_word_sel,
  input  logic [31:0]      dbg_word,
  output logic             pipe_clk_en,
  output logic             busy,
  output logic             cmd_err
);

  typedef enum logic [2:0] {HALT, RUN, STEP, D_HDR, D_SEL, D_LOAD, D_BYTE, D_WAIT} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       byte_cnt_q;
  logic [31:0]      shreg_q;
  logic             hdr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HALT;
      idx_q        <= '0;
      byte_cnt_q   <= '0;
      shreg_q      <= '0;
      hdr_q        <= 1'b0;
      tx_data      <= '0;
      tx_start     <= 1'b0;
      dbg_word_sel <= '0;
      pipe_clk_en  <= 1'b0;
      busy         <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      cmd_err  <= 1'b0;
      case (state_q)
        HALT, RUN, STEP: begin
          if (rx_done_tick && rx_data == CMD_STEP) begin
            // a step while running is a no-op: the pipeline keeps running
            state_q     <= (state_q == RUN) ? RUN : STEP;
            pipe_clk_en <= 1'b1;
          end else if (rx_done_tick && rx_data == CMD_RUN) begin
            state_q     <= RUN;
            pipe_clk_en <= 1'b1;
          end else if (rx_done_tick && rx_data == CMD_HALT) begin
            state_q     <= HALT;
            pipe_clk_en <= 1'b0;
          end else if (rx_done_tick && rx_data == CMD_DUMP) begin
            state_q     <= D_HDR;
            pipe_clk_en <= 1'b0;
            busy        <= 1'b1;
          end else begin
            state_q     <= (state_q == RUN) ? RUN : HALT;
            pipe_clk_en <= (state_q == RUN);
            cmd_err     <= rx_done_tick;
          end
        end
        D_HDR: begin
          cmd_err  <= rx_done_tick;
          tx_data  <= SYNC_BYTE;
          tx_start <= 1'b1;
          hdr_q    <= 1'b1;
          state_q  <= D_WAIT;
        end
        D_SEL: begin
          cmd_err      <= rx_done_tick;
          dbg_word_sel <= idx_q;
          state_q      <= D_LOAD;
        end
        D_LOAD: begin
          cmd_err    <= rx_done_tick;
          shreg_q    <= dbg_word;
          byte_cnt_q <= '0;
          state_q    <= D_BYTE;
        end
        D_BYTE: begin
          cmd_err  <= rx_done_tick;
          tx_data  <= shreg_q[31:24];
          tx_start <= 1'b1;
          state_q  <= D_WAIT;
        end
        D_WAIT: begin
          cmd_err <= rx_done_tick;
          if (tx_done_tick) begin
            if (hdr_q) begin
              hdr_q   <= 1'b0;
              idx_q   <= '0;
              state_q <= D_SEL;
            end else if (byte_cnt_q != 2'd3) begin
              shreg_q    <= {shreg_q[23:0], 8'h00};
              byte_cnt_q <= byte_cnt_q + 2'd1;
              state_q    <= D_BYTE;
            end else if (idx_q != IDX_W'(NUM_WORDS - 1)) begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= D_SEL;
            end else begin
              idx_q        <= '0;
              dbg_word_sel <= '0;
              busy         <= 1'b0;
              state_q      <= HALT;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_uart_ctrl.sv
// tb_debug_uart_ctrl: directed tests of command decode, clock gating and the
// two-word dump against a transmitter model that acknowledges each byte after 10 cycles.
module tb_debug_uart_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done_tick = 1'b0;
  logic        tx_done_tick = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [5:0]  dbg_word_sel;
  logic [31:0] dbg_word;
  logic        pipe_clk_en, busy, cmd_err;

  int tests = 0, fails = 0;
  int en_cnt = 0, err_cnt = 0, start_cnt = 0, overlap = 0;
  logic [7:0] txq[$];
  logic [7:0] exp_b [9] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};

  always #5 clk = ~clk;

  assign dbg_word = (dbg_word_sel == 6'd0) ? 32'h11223344 :
                    (dbg_word_sel == 6'd1) ? 32'hAABBCCDD : 32'hDEADBEEF;

  debug_uart_ctrl #(.NUM_WORDS(2), .IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
    .tx_data(tx_data), .tx_start(tx_start), .tx_done_tick(tx_done_tick),
    .dbg_word_sel(dbg_word_sel), .dbg_word(dbg_word), .pipe_clk_en(pipe_clk_en),
    .busy(busy), .cmd_err(cmd_err)
  );

  always @(negedge clk) begin
    if (pipe_clk_en) en_cnt++;
    if (cmd_err) err_cnt++;
    if (tx_start) start_cnt++;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        txq.push_back(tx_data);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (tx_start) overlap++;
        end
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1'b1;
    cyc(1);
    rx_done_tick = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && busy; i++) cyc(1);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL dump_timeout busy=%b want 0", busy); end
  endtask

  task automatic check_dump();
    tests++;
    if (txq.size() != 9) begin fails++; $display("FAIL dump_len got %0d want 9", txq.size()); end
    for (int i = 0; i < 9 && i < txq.size(); i++) begin
      tests++;
      if (txq[i] !== exp_b[i]) begin
        fails++; $display("FAIL dump_byte%0d got %h want %h", i, txq[i], exp_b[i]);
      end
    end
    tests++;
    if (overlap != 0) begin fails++; $display("FAIL tx_overlap got %0d want 0", overlap); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests++;
    if ({tx_data, tx_start, dbg_word_sel, pipe_clk_en, busy, cmd_err} !== 19'd0) begin
      fails++;
      $display("FAIL reset_vals got tx_data=%h tx_start=%b sel=%h en=%b busy=%b err=%b want all 0",
               tx_data, tx_start, dbg_word_sel, pipe_clk_en, busy, cmd_err);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    en_cnt = 0; start_cnt = 0;
    cyc(100);
    tests++;
    if (en_cnt != 0) begin fails++; $display("FAIL idle_en got %0d want 0", en_cnt); end
    tests++;
    if (start_cnt != 0) begin fails++; $display("FAIL idle_tx_start got %0d want 0", start_cnt); end
  endtask

  task automatic test_step();
    en_cnt = 0;
    send(8'h73);
    tests++;
    if (pipe_clk_en !== 1'b1) begin fails++; $display("FAIL step1_en got %b want 1", pipe_clk_en); end
    cyc(1);
    tests++;
    if (pipe_clk_en !== 1'b0) begin fails++; $display("FAIL step1_off got %b want 0", pipe_clk_en); end
    cyc(5);
    tests++;
    if (en_cnt != 1) begin fails++; $display("FAIL step1_cnt got %0d want 1", en_cnt); end
    send(8'h73);
    cyc(6);
    tests++;
    if (en_cnt != 2) begin fails++; $display("FAIL step2_cnt got %0d want 2", en_cnt); end
  endtask

  task automatic test_run_halt();
    en_cnt = 0;
    send(8'h63);
    cyc(19);
    send(8'h68);
    tests++;
    if (pipe_clk_en !== 1'b0) begin fails++; $display("FAIL halt_en got %b want 0", pipe_clk_en); end
    cyc(5);
    tests++;
    if (en_cnt != 20) begin fails++; $display("FAIL run_cycles got %0d want 20", en_cnt); end
  endtask

  task automatic test_dump();
    send(8'h63);
    cyc(3);
    txq.delete(); overlap = 0;
    send(8'h64);
    tests++;
    if (busy !== 1'b1 || pipe_clk_en !== 1'b0) begin
      fails++; $display("FAIL dump_start got busy=%b en=%b want busy=1 en=0", busy, pipe_clk_en);
    end
    wait_idle();
    check_dump();
    tests++;
    if (dbg_word_sel !== 6'd0) begin fails++; $display("FAIL dump_sel got %h want 0", dbg_word_sel); end
    en_cnt = 0;
    cyc(10);
    tests++;
    if (en_cnt != 0) begin fails++; $display("FAIL dump_end_halt got %0d want 0", en_cnt); end
  endtask

  task automatic test_busy_drop();
    txq.delete(); overlap = 0; err_cnt = 0;
    send(8'h64);
    cyc(30);
    send(8'h63);
    tests++;
    if (cmd_err !== 1'b1) begin fails++; $display("FAIL busy_err got %b want 1", cmd_err); end
    cyc(1);
    tests++;
    if (cmd_err !== 1'b0) begin fails++; $display("FAIL busy_err_pulse got %b want 0", cmd_err); end
    wait_idle();
    check_dump();
    en_cnt = 0;
    cyc(10);
    tests++;
    if (en_cnt != 0 || err_cnt != 1) begin
      fails++; $display("FAIL busy_end got en_cnt=%0d err_cnt=%0d want 0 1", en_cnt, err_cnt);
    end
  endtask

  task automatic test_unknown();
    err_cnt = 0;
    send(8'h7A);
    tests++;
    if (cmd_err !== 1'b1 || pipe_clk_en !== 1'b0) begin
      fails++; $display("FAIL unk_halt got err=%b en=%b want 1 0", cmd_err, pipe_clk_en);
    end
    send(8'h63);
    send(8'h7A);
    tests++;
    if (cmd_err !== 1'b1 || pipe_clk_en !== 1'b1) begin
      fails++; $display("FAIL unk_run got err=%b en=%b want 1 1", cmd_err, pipe_clk_en);
    end
    send(8'h68);
    cyc(2);
    tests++;
    if (err_cnt != 2 || pipe_clk_en !== 1'b0) begin
      fails++; $display("FAIL unk_end got err_cnt=%0d en=%b want 2 0", err_cnt, pipe_clk_en);
    end
  endtask

  task automatic test_reset_mid_dump();
    send(8'h64);
    cyc(40);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({tx_data, tx_start, dbg_word_sel, pipe_clk_en, busy, cmd_err} !== 19'd0) begin
      fails++;
      $display("FAIL mid_reset got tx_data=%h tx_start=%b sel=%h en=%b busy=%b err=%b want all 0",
               tx_data, tx_start, dbg_word_sel, pipe_clk_en, busy, cmd_err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_cnt = 0;
    cyc(100);
    tests++;
    if (start_cnt != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL post_reset got starts=%0d busy=%b want 0 0", start_cnt, busy);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_run_halt();
    test_dump();
    test_busy_drop();
    test_unknown();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
